// File: rtl/memips_bus_pkg.sv
// Shared bus definitions for the MeMIPS data/instruction memory path:
// responder states, the latched request record and the console MMIO address.
package memips_bus_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   localparam logic [BUS_AW-1:0] MMIO_CONSOLE_ADDR = 32'hFFFF_FFF0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic              we;
      logic [BUS_AW-1:0] addr;
      logic [3:0]        be;
      logic [BUS_DW-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/memips_sram_be.sv
// Word-wide synchronous RAM with per-byte write enables.
// Read data is registered and holds its value until the next enabled read.
module memips_sram_be
   import memips_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter     INIT_FILE   = "",
   localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [BUS_DW-1:0] wdata_i,
   output logic [BUS_DW-1:0] rdata_o
);

   logic [BUS_DW-1:0] mem [DEPTH_WORDS];
   logic [BUS_DW-1:0] rdata_q;

   // Enabled cycles either merge the selected byte lanes into the word or register a read.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < 4; i++) begin
               if (be_i[i]) begin
                  mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memips_dmem_responder.sv
// Single-outstanding load/store responder in front of memips_sram_be.
// Optional console MMIO store/load at MMIO_CONSOLE_ADDR when MEMIPS_MMIO_CONSOLE_EN is defined.
module memips_dmem_responder
   import memips_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [BUS_AW-1:0] req_addr,
   input  logic [3:0]        req_be,
   input  logic [BUS_DW-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [BUS_DW-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_e       state_q, state_d;
   bus_req_t          req_q, req_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              mmio_q, mmio_d;
   logic              ready_q, ready_d;
   logic              accept, commit;
   logic              misaligned, outOfRange, isConsole;
   logic [BUS_DW-1:0] sramRdata;
   logic              unusedAddrBits;

   assign accept     = (state_q == IDLE) && req_valid && ready_q;
   assign commit     = (state_q == WAIT) && (cnt_q == 4'd0);
   assign misaligned = |req_addr[1:0];
   assign outOfRange = req_addr[BUS_AW-1:2] >= 30'(DEPTH_WORDS);

`ifdef MEMIPS_MMIO_CONSOLE_EN
   assign isConsole = (req_addr == MMIO_CONSOLE_ADDR);
`else
   assign isConsole = 1'b0;
`endif

   // Classification is decided once at accept so the response stays stable in RESP.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      mmio_d  = mmio_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_d.we    = req_we;
               req_d.addr  = req_addr;
               req_d.be    = req_be;
               req_d.wdata = req_wdata;
               cnt_d       = 4'(LATENCY);
               err_d       = misaligned || (outOfRange && !isConsole);
               mmio_d      = isConsole;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready_d = (state_d == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         mmio_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mmio_q  <= mmio_d;
         ready_q <= ready_d;
      end
   end

   memips_sram_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_sram (
      .clk     (clk),
      .en_i    (commit && !err_q && !mmio_q),
      .we_i    (req_q.we),
      .be_i    (req_q.be),
      .addr_i  (req_q.addr[IDX_W+1:2]),
      .wdata_i (req_q.wdata),
      .rdata_o (sramRdata)
   );

   assign unusedAddrBits = ^req_q.addr;

`ifdef MEMIPS_MMIO_CONSOLE_EN
   always_ff @(posedge clk) begin
      if (commit && mmio_q && req_q.we && req_q.be[0]) begin
         $write("%c", req_q.wdata[7:0]);
      end
   end
`endif

   // Read data only surfaces for successful array loads; everything else reads as zero.
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && !err_q && !mmio_q && !req_q.we) ? sramRdata : '0;
   assign req_ready = ready_q;

endmodule

// File: tb/tb_memips_dmem_responder.sv
// Randomized self-checking bench for memips_dmem_responder against a word-array model.
// Console expectations follow MEMIPS_MMIO_CONSOLE_EN when the bench is built with it.
module tb_memips_dmem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 3;
`ifdef MEMIPS_MMIO_CONSOLE_EN
   localparam bit CONSOLE_EN = 1'b1;
`else
   localparam bit CONSOLE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelMem [DEPTH];

   memips_dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .INIT_FILE   ("")
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Reference rules: aligned words below DEPTH are legal, plus the console address when enabled.
   function automatic bit expErr(input logic [31:0] a);
      if (CONSOLE_EN && a == 32'hFFFF_FFF0) return 1'b0;
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   function automatic logic [31:0] expData(input logic we, input logic [31:0] a);
      if (we || expErr(a) || a >= 32'(DEPTH * 4)) return 32'h0;
      return modelMem[a / 4];
   endfunction

   task automatic modelStore(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      if (expErr(a) || a >= 32'(DEPTH * 4)) return;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) modelMem[a / 4][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   // Presents one request, waits for acceptance and counts edges until rsp_valid.
   task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] d, output int lat);
      int guard = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = d;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_be    = 4'($urandom);
      req_wdata = $urandom;
      lat = 0;
      while (!rsp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic completeResponse(input int hold, output logic [31:0] rd, output logic er);
      rd = rsp_rdata;
      er = rsp_err;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
      #12;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err got %b exp 0", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 0", req_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #2;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_req_ready got %b exp 0", req_ready); end
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_edge_req_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_latency;
      int lat; logic [31:0] rd; logic er;
      applyStimulus(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat);
      modelStore(32'h10, 4'hF, 32'hDEAD_BEEF);
      checks++; if (lat != 1 + LAT) begin errors++; $display("[TB] FAIL store_latency got %0d exp %0d", lat, 1 + LAT); end
      completeResponse(0, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("[TB] FAIL store_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_handshake got %b exp 1", req_ready); end
      applyStimulus(1'b0, 32'h10, 4'h0, 32'h0, lat);
      checks++; if (lat != 1 + LAT) begin errors++; $display("[TB] FAIL load_latency got %0d exp %0d", lat, 1 + LAT); end
      completeResponse(0, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_0x10 got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
   endtask

   task automatic test_byte_enable;
      int lat; logic [31:0] rd; logic er;
      applyStimulus(1'b1, 32'h20, 4'hF, 32'hAAAA_AAAA, lat);
      completeResponse(1, rd, er);
      modelStore(32'h20, 4'hF, 32'hAAAA_AAAA);
      applyStimulus(1'b1, 32'h20, 4'b0101, 32'h1122_3344, lat);
      completeResponse(0, rd, er);
      modelStore(32'h20, 4'b0101, 32'h1122_3344);
      applyStimulus(1'b0, 32'h20, 4'b0001, 32'h0, lat);
      completeResponse(2, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'hAA22_AA44) begin errors++; $display("[TB] FAIL byte_lanes got err=%b rdata=%h exp err=0 rdata=aa22aa44", er, rd); end
      applyStimulus(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, lat);
      completeResponse(0, rd, er);
      checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL noop_store_err got %b exp 0", er); end
      applyStimulus(1'b0, 32'h20, 4'h0, 32'h0, lat);
      completeResponse(0, rd, er);
      checks++; if (rd !== expData(1'b0, 32'h20)) begin errors++; $display("[TB] FAIL noop_store_data got %h exp %h", rd, expData(1'b0, 32'h20)); end
   endtask

   task automatic test_errors;
      int lat; logic [31:0] rd; logic er;
      logic [31:0] addrs [4];
      logic        wes [4];
      addrs[0] = 32'h22;                  wes[0] = 1'b0;
      addrs[1] = 32'(DEPTH * 4);          wes[1] = 1'b0;
      addrs[2] = 32'(DEPTH * 4) + 32'h20; wes[2] = 1'b1;
      addrs[3] = 32'h21;                  wes[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(wes[i], addrs[i], 4'hF, 32'h5555_5555, lat);
         completeResponse(0, rd, er);
         checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL err_addr_%h got err=%b rdata=%h exp err=1 rdata=0", addrs[i], er, rd); end
      end
      applyStimulus(1'b0, 32'h20, 4'h0, 32'h0, lat);
      completeResponse(0, rd, er);
      checks++; if (rd !== expData(1'b0, 32'h20)) begin errors++; $display("[TB] FAIL err_array_untouched got %h exp %h", rd, expData(1'b0, 32'h20)); end
   endtask

   task automatic test_backpressure;
      int lat; logic [31:0] rd; logic er;
      applyStimulus(1'b0, 32'h10, 4'h0, 32'h0, lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== expData(1'b0, 32'h10) || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_cycle_%0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=%h ready=0",
                     i, rsp_valid, rsp_rdata, req_ready, expData(1'b0, 32'h10));
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      completeResponse(0, rd, er);
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL after_hold got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
      applyStimulus(1'b0, 32'h10, 4'h0, 32'h0, lat);
      completeResponse(0, rd, er);
      checks++; if (rd !== expData(1'b0, 32'h10)) begin errors++; $display("[TB] FAIL ignored_req got %h exp %h", rd, expData(1'b0, 32'h10)); end
   endtask

   task automatic test_reset_in_wait;
      int lat; int guard; logic [31:0] rd; logic er;
      applyStimulus(1'b1, 32'h30, 4'hF, 32'h1234_5678, lat);
      completeResponse(0, rd, er);
      modelStore(32'h30, 4'hF, 32'h1234_5678);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_be = 4'hF; req_wdata = 32'hCAFE_F00D;
      guard = 0;
      while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL wait_reset got valid=%b ready=%b err=%b exp 0 0 0", rsp_valid, req_ready, rsp_err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_reset_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
      repeat (6) begin @(posedge clk); #1; end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL dropped_rsp got valid=%b exp 0", rsp_valid); end
      applyStimulus(1'b0, 32'h30, 4'h0, 32'h0, lat);
      completeResponse(0, rd, er);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL dropped_store got %h exp 12345678", rd); end
   endtask

   task automatic test_mmio;
      int lat; logic [31:0] rd; logic er;
      applyStimulus(1'b1, 32'hFFFF_FFF0, 4'b0001, 32'h0000_0041, lat);
      completeResponse(0, rd, er);
      checks++; if (er !== !CONSOLE_EN || rd !== 32'h0) begin errors++; $display("[TB] FAIL console_store got err=%b rdata=%h exp err=%b rdata=0", er, rd, !CONSOLE_EN); end
      applyStimulus(1'b0, 32'hFFFF_FFF0, 4'h0, 32'h0, lat);
      completeResponse(0, rd, er);
      checks++; if (er !== !CONSOLE_EN || rd !== 32'h0) begin errors++; $display("[TB] FAIL console_load got err=%b rdata=%h exp err=%b rdata=0", er, rd, !CONSOLE_EN); end
   endtask

   task automatic test_random;
      int lat; logic [31:0] rd; logic er;
      logic [31:0] a, d; logic we; logic [3:0] be; int w;
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         applyStimulus(1'b1, 32'(i * 4), 4'hF, d, lat);
         completeResponse(0, rd, er);
         modelStore(32'(i * 4), 4'hF, d);
      end
      for (int n = 0; n < 80; n++) begin
         w  = $urandom_range(0, DEPTH + 3);
         a  = 32'(w * 4);
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
         we = 1'($urandom);
         be = 4'($urandom);
         d  = $urandom;
         applyStimulus(we, a, be, d, lat);
         checks++; if (lat != 1 + LAT) begin errors++; $display("[TB] FAIL rand_latency_%0d got %0d exp %0d", n, lat, 1 + LAT); end
         completeResponse($urandom_range(0, 3), rd, er);
         checks++;
         if (er !== expErr(a) || rd !== expData(we, a)) begin
            errors++;
            $display("[TB] FAIL rand_txn_%0d we=%b addr=%h got err=%b rdata=%h exp err=%b rdata=%h",
                     n, we, a, er, rd, expErr(a), expData(we, a));
         end
         if (we) modelStore(a, be, d);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_byte_enable();
      test_errors();
      test_backpressure();
      test_reset_in_wait();
      test_mmio();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
